dcache_dm: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate data cache for the RV32I core's load/store port.
- Replaces the single-cycle data block with a tagged line store in front of an external data memory, reached over a req/ack handshake.
- Keeps the core-facing clk_stall contract and the memory-mapped LED register.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_lane_fmt.sv | 47 ++++
 rtl/dcache_dm.sv | 206 ++++++++++++++++++++
 tb/tb_dcache_dm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL,
      RESPOND,
      WRITE_MEM
   } state_t;

   localparam logic [2:0] SZ_BYTE = 3'b001;
   localparam logic [2:0] SZ_HALF = 3'b011;
   localparam logic [2:0] SZ_WORD = 3'b111;

   function automatic int word_bits(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int index_bits(input int lines);
      return $clog2(lines);
   endfunction

   // Word address is 30 bits wide; whatever the index and word fields leave is tag.
   function automatic int tag_bits(input int lines, input int words_per_line);
      return 30 - $clog2(lines) - $clog2(words_per_line);
   endfunction

endpackage

// File: rtl/dcache_lane_fmt.sv
// Little-endian lane handling: load extract/extend, store replicate and byte enables.
module dcache_lane_fmt
   import dcache_pkg::*;
(
   input  logic [3:0]  sign_mask,
   input  logic [1:0]  offset,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word,
   output logic [3:0]  be
);

   logic [2:0]  size_sel;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Unknown size encodings fall back to a full-word access.
   always_comb begin
      size_sel = SZ_WORD;
      if (sign_mask[2:0] == SZ_BYTE || sign_mask[2:0] == SZ_HALF)
         size_sel = sign_mask[2:0];
   end

   assign byte_sel = rword[{offset, 3'b000} +: 8];
   assign half_sel = offset[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      load_val   = rword;
      store_word = wdata;
      be         = 4'b1111;
      case (size_sel)
         SZ_BYTE: begin
            load_val   = sign_mask[3] ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            store_word = {4{wdata[7:0]}};
            be         = 4'b0001 << offset;
         end
         SZ_HALF: begin
            load_val   = sign_mask[3] ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            store_word = {2{wdata[15:0]}};
            be         = offset[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with an uncached LED register.
module dcache_dm
   import dcache_pkg::*;
#(
   parameter int          LINES          = 16,
   parameter int          WORDS_PER_LINE = 4,
   parameter logic [31:0] DATA_BASE      = 32'h1000,
   parameter logic [31:0] LED_ADDR       = 32'h2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [3:0]  sign_mask,
   output logic [31:0] read_data,
   output logic        clk_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [7:0]  led
);

   localparam int WB = word_bits(WORDS_PER_LINE);
   localparam int IB = index_bits(LINES);
   localparam int TW = tag_bits(LINES, WORDS_PER_LINE);
   localparam int FW = IB + WB;
   localparam int CW = WB + 1;

   state_t state, state_nx;

   logic [31:0] req_addr, req_off, req_wdata;
   logic [3:0]  req_mask;
   logic        req_wr;

   logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
   logic [TW-1:0]    tag_mem  [LINES];
   logic [LINES-1:0] valid;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [31:0]      led_reg, led_nx;

   logic [FW-1:0] req_flat, fill_flat;
   logic [IB-1:0] req_idx;
   logic [TW-1:0] req_tag;
   logic          hit, is_led, ack_ok, last_word;
   logic [31:0]   cur_word, load_val, store_word, be_mask, merged, line_waddr;
   logic [3:0]    be;

   logic        stall_nx, req_nx, we_nx;
   logic [31:0] addr_nx, wdata_nx, rdata_nx;
   logic [3:0]  be_nx;
   logic        fill_we, hit_we, line_done;

   assign req_flat   = req_off[2 +: FW];
   assign req_idx    = req_off[2+WB +: IB];
   assign req_tag    = req_off[2+FW +: TW];
   assign hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign is_led     = (req_addr == LED_ADDR);
   assign ack_ok     = mem_req & mem_ack;
   assign last_word  = (cnt == CW'(WORDS_PER_LINE - 1));
   assign line_waddr = {2'b00, req_off[31:2]} & ~32'(WORDS_PER_LINE - 1);
   assign fill_flat  = (req_flat & ~FW'(WORDS_PER_LINE - 1)) | FW'(cnt);
   assign cur_word   = data_mem[req_flat];
   assign be_mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign merged     = (cur_word & ~be_mask) | (store_word & be_mask);
   assign led        = led_reg[7:0];

   dcache_lane_fmt u_lane_fmt (
      .sign_mask  (req_mask),
      .offset     (req_off[1:0]),
      .rword      (cur_word),
      .wdata      (req_wdata),
      .load_val   (load_val),
      .store_word (store_word),
      .be         (be)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (memwrite | memread) state_nx = LOOKUP;
         LOOKUP: begin
            if (is_led)      state_nx = IDLE;
            else if (req_wr) state_nx = WRITE_MEM;
            else if (hit)    state_nx = IDLE;
            else             state_nx = REFILL;
         end
         REFILL:    if (ack_ok && last_word) state_nx = RESPOND;
         RESPOND:   state_nx = IDLE;
         WRITE_MEM: if (ack_ok) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Next values of the registered outputs plus array write strobes.
   always_comb begin
      stall_nx  = clk_stall;
      req_nx    = mem_req;
      we_nx     = mem_we;
      addr_nx   = mem_addr;
      wdata_nx  = mem_wdata;
      be_nx     = mem_be;
      rdata_nx  = read_data;
      led_nx    = led_reg;
      cnt_nx    = cnt;
      fill_we   = 1'b0;
      hit_we    = 1'b0;
      line_done = 1'b0;
      case (state)
         IDLE: if (memwrite | memread) stall_nx = 1'b1;
         LOOKUP: begin
            if (is_led) begin
               stall_nx = 1'b0;
               if (req_wr) led_nx   = req_wdata;
               else        rdata_nx = led_reg;
            end else if (req_wr) begin
               hit_we   = hit;
               req_nx   = 1'b1;
               we_nx    = 1'b1;
               addr_nx  = {2'b00, req_off[31:2]};
               wdata_nx = store_word;
               be_nx    = be;
            end else if (hit) begin
               rdata_nx = load_val;
               stall_nx = 1'b0;
            end else begin
               cnt_nx  = '0;
               req_nx  = 1'b1;
               we_nx   = 1'b0;
               addr_nx = line_waddr;
            end
         end
         REFILL: begin
            if (ack_ok) begin
               fill_we   = 1'b1;
               cnt_nx    = cnt + CW'(1);
               req_nx    = 1'b0;
               line_done = last_word;
            end else if (!mem_req) begin
               req_nx  = 1'b1;
               addr_nx = line_waddr | 32'(cnt);
            end
         end
         RESPOND: begin
            rdata_nx = load_val;
            stall_nx = 1'b0;
         end
         WRITE_MEM: begin
            if (ack_ok) begin
               req_nx   = 1'b0;
               we_nx    = 1'b0;
               stall_nx = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_stall <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         read_data <= '0;
         led_reg   <= '0;
         valid     <= '0;
         cnt       <= '0;
      end else begin
         clk_stall <= stall_nx;
         mem_req   <= req_nx;
         mem_we    <= we_nx;
         read_data <= rdata_nx;
         led_reg   <= led_nx;
         cnt       <= cnt_nx;
         if (line_done) valid[req_idx] <= 1'b1;
      end
   end

   // Request capture, memory-side fields and line storage carry no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         req_addr  <= addr;
         req_off   <= addr - DATA_BASE;
         req_wdata <= write_data;
         req_mask  <= sign_mask;
         req_wr    <= memwrite;
      end
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      mem_be    <= be_nx;
      if (fill_we)   data_mem[fill_flat] <= mem_rdata;
      if (hit_we)    data_mem[req_flat]  <= merged;
      if (line_done) tag_mem[req_idx]    <= req_tag;
   end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm with a one-cycle-latency word memory model.
module tb_dcache_dm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, write_data;
   logic        memwrite, memread;
   logic [3:0]  sign_mask;
   logic [31:0] read_data;
   logic        clk_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [7:0]  led;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [512];
   int          rd_total, wr_total;
   logic [31:0] rd_log [8];
   logic [3:0]  last_be;
   logic [31:0] last_wdata;

   always #5 clk = ~clk;

   dcache_dm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (addr),
      .write_data (write_data),
      .memwrite   (memwrite),
      .memread    (memread),
      .sign_mask  (sign_mask),
      .read_data  (read_data),
      .clk_stall  (clk_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .led        (led)
   );

   // Memory model: acknowledges a pending request one cycle after seeing it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ack  <= 1'b0;
         rd_total <= 0;
         wr_total <= 0;
         for (int i = 0; i < 512; i++) mem[i] <= 32'hC000_0000 | i;
         mem[4] <= 32'h1122_3344;
         mem[5] <= 32'h5566_7788;
         mem[6] <= 32'h99AA_BBCC;
         mem[7] <= 32'hDDEE_FF00;
      end else if (mem_ack) begin
         mem_ack <= 1'b0;
      end else if (mem_req) begin
         mem_ack <= 1'b1;
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr[8:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            last_be    <= mem_be;
            last_wdata <= mem_wdata;
            wr_total   <= wr_total + 1;
         end else begin
            mem_rdata            <= mem[mem_addr[8:0]];
            rd_log[rd_total % 8] <= mem_addr;
            rd_total             <= rd_total + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m,
                         output int stall, output int rdh, output int wrh);
      int rd0, wr0;
      rd0 = rd_total;
      wr0 = wr_total;
      @(negedge clk);
      memwrite = wr; memread = rd; addr = a; write_data = wd; sign_mask = m;
      @(posedge clk);
      #1 memwrite = 1'b0; memread = 1'b0;
      stall = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!clk_stall) break;
         stall++;
      end
      if (clk_stall) begin
         total++; bad++;
         $display("FAIL timeout addr=%h: clk_stall still 1, expected 0", a);
      end
      rdh = rd_total - rd0;
      wrh = wr_total - wr0;
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  m;
      logic [31:0] exp_rd;
      int          rdh;
      int          wrh;
      int          stall;
      logic [3:0]  be;
      logic [31:0] mwd;
   } vec_t;

   vec_t v [24];

   initial begin
      int st, rh, wh;
      bit found;

      v[0]  = '{1'b0, 1'b1, 32'h1010, 32'h0, 4'h7, 32'h1122_3344, 4, 0, 0, 4'h0, 32'h0};
      v[1]  = '{1'b0, 1'b1, 32'h1010, 32'h0, 4'h7, 32'h1122_3344, 0, 0, 1, 4'h0, 32'h0};
      v[2]  = '{1'b0, 1'b1, 32'h1018, 32'h0, 4'h7, 32'h99AA_BBCC, 0, 0, 1, 4'h0, 32'h0};
      v[3]  = '{1'b1, 1'b0, 32'h1011, 32'h80, 4'h1, 32'h99AA_BBCC, 0, 1, 0, 4'b0010, 32'h8080_8080};
      v[4]  = '{1'b0, 1'b1, 32'h1011, 32'h0, 4'h9, 32'hFFFF_FF80, 0, 0, 1, 4'h0, 32'h0};
      v[5]  = '{1'b0, 1'b1, 32'h1011, 32'h0, 4'h1, 32'h0000_0080, 0, 0, 1, 4'h0, 32'h0};
      v[6]  = '{1'b0, 1'b1, 32'h1012, 32'h0, 4'hB, 32'h0000_1122, 0, 0, 1, 4'h0, 32'h0};
      v[7]  = '{1'b0, 1'b1, 32'h1018, 32'h0, 4'hB, 32'hFFFF_BBCC, 0, 0, 1, 4'h0, 32'h0};
      v[8]  = '{1'b0, 1'b1, 32'h1019, 32'h0, 4'h3, 32'h0000_BBCC, 0, 0, 1, 4'h0, 32'h0};
      v[9]  = '{1'b1, 1'b0, 32'h101E, 32'h1234_BEEF, 4'h3, 32'h0000_BBCC, 0, 1, 0, 4'b1100, 32'hBEEF_BEEF};
      v[10] = '{1'b0, 1'b1, 32'h101C, 32'h0, 4'h7, 32'hBEEF_FF00, 0, 0, 1, 4'h0, 32'h0};
      v[11] = '{1'b1, 1'b0, 32'h1400, 32'hCAFE_F00D, 4'h7, 32'hBEEF_FF00, 0, 1, 0, 4'hF, 32'hCAFE_F00D};
      v[12] = '{1'b0, 1'b1, 32'h1400, 32'h0, 4'h7, 32'hCAFE_F00D, 4, 0, 0, 4'h0, 32'h0};
      v[13] = '{1'b1, 1'b0, 32'h2000, 32'hA5, 4'h7, 32'hCAFE_F00D, 0, 0, 1, 4'h0, 32'h0};
      v[14] = '{1'b0, 1'b1, 32'h2000, 32'h0, 4'h7, 32'h0000_00A5, 0, 0, 1, 4'h0, 32'h0};
      v[15] = '{1'b0, 1'b1, 32'h1110, 32'h0, 4'h7, 32'hC000_0044, 4, 0, 0, 4'h0, 32'h0};
      v[16] = '{1'b0, 1'b1, 32'h1010, 32'h0, 4'h7, 32'h1122_8044, 4, 0, 0, 4'h0, 32'h0};
      v[17] = '{1'b0, 1'b1, 32'h1110, 32'h0, 4'h7, 32'hC000_0044, 4, 0, 0, 4'h0, 32'h0};
      v[18] = '{1'b0, 1'b1, 32'h1113, 32'h0, 4'h7, 32'hC000_0044, 0, 0, 1, 4'h0, 32'h0};
      v[19] = '{1'b0, 1'b1, 32'h1111, 32'h0, 4'h5, 32'hC000_0044, 0, 0, 1, 4'h0, 32'h0};
      v[20] = '{1'b1, 1'b1, 32'h1114, 32'h0BAD_F00D, 4'h7, 32'hC000_0044, 0, 1, 0, 4'hF, 32'h0BAD_F00D};
      v[21] = '{1'b0, 1'b1, 32'h1114, 32'h0, 4'h7, 32'h0BAD_F00D, 0, 0, 1, 4'h0, 32'h0};
      v[22] = '{1'b0, 1'b1, 32'h1116, 32'h0, 4'h9, 32'hFFFF_FFAD, 0, 0, 1, 4'h0, 32'h0};
      v[23] = '{1'b0, 1'b1, 32'h1117, 32'h0, 4'h9, 32'h0000_000B, 0, 0, 1, 4'h0, 32'h0};

      rst_n = 1'b0; memwrite = 1'b0; memread = 1'b0;
      addr = '0; write_data = '0; sign_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset clk_stall", 32'(clk_stall), 32'd0);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset read_data", read_data, 32'd0);
      chk("reset led", 32'(led), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         access(v[i].wr, v[i].rd, v[i].a, v[i].wd, v[i].m, st, rh, wh);
         chk($sformatf("v%0d read_data", i), read_data, v[i].exp_rd);
         chk($sformatf("v%0d read handshakes", i), 32'(rh), 32'(v[i].rdh));
         chk($sformatf("v%0d write handshakes", i), 32'(wh), 32'(v[i].wrh));
         if (v[i].stall != 0)
            chk($sformatf("v%0d stall cycles", i), 32'(st), 32'(v[i].stall));
         if (v[i].wrh != 0) begin
            chk($sformatf("v%0d mem_be", i), 32'(last_be), 32'(v[i].be));
            chk($sformatf("v%0d mem_wdata", i), last_wdata, v[i].mwd);
         end
         if (i == 0)
            for (int k = 0; k < 4; k++)
               chk($sformatf("cold refill addr %0d", k), rd_log[k], 32'(4 + k));
      end
      chk("led after store", 32'(led), 32'hA5);

      // Reset while the second word of a refill is outstanding.
      @(negedge clk);
      begin
         int rd0;
         rd0 = rd_total;
         memread = 1'b1; addr = 32'h1020; sign_mask = 4'h7;
         @(posedge clk);
         #1 memread = 1'b0;
         found = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_total - rd0 == 1 && mem_req) begin
               found = 1'b1;
               break;
            end
         end
      end
      chk("second refill request seen", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort clk_stall", 32'(clk_stall), 32'd0);
      chk("abort mem_req", 32'(mem_req), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      access(1'b0, 1'b1, 32'h1020, 32'h0, 4'h7, st, rh, wh);
      chk("post-abort read_data", read_data, 32'hC000_0008);
      chk("post-abort read handshakes", 32'(rh), 32'd4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("post-abort refill addr %0d", k), rd_log[k], 32'(8 + k));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

endmodule
